itof_pipe: RTL and testbench

- Pipelined signed 32-bit integer to IEEE-754 single-precision converter.
- Counterpart stage to the FPU's float-to-int unit. Consumes integer operands from the integer datapath/issue logic and produces float results for the FPU writeback path.
- Three-stage pipeline with valid/ready handshake on both sides and a global stall. Accepts one conversion per cycle when not back-pressured.

---
 rtl/itof_pipe.sv | 137 +++++++++++++
 tb/tb_itof_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itof_pipe.sv
// Pipelined signed 32-bit integer to IEEE-754 single-precision converter.
// Input register, magnitude, normalise and round/pack ranks share one global enable.
module itof_pipe #(
  parameter bit TIES_AWAY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  logic        en;

  logic        s0_valid_q, s0_valid_d;
  logic [31:0] s0_op_q,    s0_op_d;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q,  s1_sign_d;
  logic        s1_zero_q,  s1_zero_d;
  logic [31:0] s1_mag_q,   s1_mag_d;

  logic        s2_valid_q, s2_valid_d;
  logic        s2_sign_q,  s2_sign_d;
  logic        s2_zero_q,  s2_zero_d;
  logic [7:0]  s2_exp_q,   s2_exp_d;
  logic [30:0] s2_norm_q,  s2_norm_d;  // hidden leading one is not stored

  logic        s3_valid_q, s3_valid_d;
  logic [31:0] s3_result_q, s3_result_d;

  logic [4:0]  lz;
  logic        lz_found;
  logic [22:0] mant, mant_r;
  logic        guard, sticky, lsb, round_up, carry;
  logic [7:0]  exp_r;
  logic [31:0] packed_res;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = s3_valid_q;
  assign result    = s3_result_q;

  // Leading-zero count; a zero magnitude leaves lz at 0 and is masked at pack.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!lz_found && s1_mag_q[i]) begin
        lz       = 5'(31 - i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    mant     = s2_norm_q[30:8];
    lsb      = s2_norm_q[8];
    guard    = s2_norm_q[7];
    sticky   = |s2_norm_q[6:0];
    round_up = TIES_AWAY ? guard : (guard & (sticky | lsb));
    {carry, mant_r} = {1'b0, mant} + {23'd0, round_up};
    exp_r      = s2_exp_q + {7'd0, carry};
    packed_res = s2_zero_q ? 32'h0000_0000 : {s2_sign_q, exp_r, mant_r};
  end

  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_op_d     = s0_op_q;
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_zero_d   = s1_zero_q;
    s1_mag_d    = s1_mag_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_exp_d    = s2_exp_q;
    s2_norm_d   = s2_norm_q;
    s3_valid_d  = s3_valid_q;
    s3_result_d = s3_result_q;
    if (en) begin
      s0_valid_d  = in_valid;
      s0_op_d     = op;
      s1_valid_d  = s0_valid_q;
      s1_sign_d   = s0_op_q[31];
      s1_zero_d   = (s0_op_q == 32'd0);
      s1_mag_d    = s0_op_q[31] ? (~s0_op_q + 32'd1) : s0_op_q;
      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_zero_d   = s1_zero_q;
      s2_exp_d    = 8'd158 - {3'b000, lz};
      s2_norm_d   = 31'(s1_mag_q << lz);
      s3_valid_d  = s2_valid_q;
      s3_result_d = packed_res;
    end
  end

  // NOTE: data registers are reset along with the valid bits so nothing
  // downstream ever sees X, and result reads 0 during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_valid_q  <= 1'b0;
      s0_op_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_norm_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_result_q <= '0;
    end else begin
      // NOTE: non-blocking so every rank samples the previous rank's old value.
      s0_valid_q  <= s0_valid_d;
      s0_op_q     <= s0_op_d;
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_exp_q    <= s2_exp_d;
      s2_norm_q   <= s2_norm_d;
      s3_valid_q  <= s3_valid_d;
      s3_result_q <= s3_result_d;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed vectors, back-pressure, bubbles,
// mid-stream reset and a randomized scoreboard run against an arithmetic model.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] op;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic        ta_in_ready, ta_out_valid;
  logic [31:0] ta_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  itof_pipe #(.TIES_AWAY(1'b0)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  itof_pipe #(.TIES_AWAY(1'b1)) dut_ta (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ta_in_ready), .op(op),
    .out_valid(ta_out_valid), .out_ready(out_ready), .result(ta_result)
  );

  typedef struct {
    logic [31:0] op;
    logic [31:0] rne;
    logic [31:0] away;
  } vec_t;

  localparam int NVEC = 11;
  vec_t tbl [NVEC];

  logic [31:0] sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference conversion from the numeric value: find the binade, keep 24
  // significant bits, round on the discarded remainder.
  function automatic logic [31:0] model(input logic [31:0] v, input bit away);
    longint m, q, rem, half;
    int     e, shift;
    bit     s;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    m = longint'({32'd0, v});
    if (s) m = 64'sh1_0000_0000 - m;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      shift = e - 23;
      q     = m >> shift;
      rem   = m - (q << shift);
      half  = longint'(1) << (shift - 1);
      if (rem > half || (rem == half && (away || q[0]))) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 1000);
      2: v = (32'h0100_0000 | ($urandom & 32'h00FF_FFFF)) << $urandom_range(0, 6);
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h8000_0000;
          1: v = 32'h7FFF_FFFF;
          2: v = 32'd0;
          default: v = 32'hFFFF_FFFF;
        endcase
      end
    endcase
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_ops [5];
    logic [31:0] bp_exp [5];
    logic [31:0] e;
    int k, m, stall;
    bit bp_started, pending;

    tbl[0]  = '{32'd0,        32'h0000_0000, 32'h0000_0000};
    tbl[1]  = '{32'd1,        32'h3F80_0000, 32'h3F80_0000};
    tbl[2]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 32'hBF80_0000};
    tbl[3]  = '{32'd3,        32'h4040_0000, 32'h4040_0000};
    tbl[4]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 32'h4F00_0000};
    tbl[5]  = '{32'h8000_0000, 32'hCF00_0000, 32'hCF00_0000};
    tbl[6]  = '{32'd16777216, 32'h4B80_0000, 32'h4B80_0000};
    tbl[7]  = '{32'd16777217, 32'h4B80_0000, 32'h4B80_0001};
    tbl[8]  = '{32'd16777219, 32'h4B80_0002, 32'h4B80_0002};
    tbl[9]  = '{-32'sd16777217, 32'hCB80_0000, 32'hCB80_0001};
    tbl[10] = '{32'd16777218, 32'h4B80_0001, 32'h4B80_0001};

    bp_ops = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    bp_exp = '{32'h4120_0000, 32'h41A0_0000, 32'h41F0_0000, 32'h4220_0000, 32'h4248_0000};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back table vectors, exact latency of three edges after acceptance.
    for (int j = 0; j < NVEC + 4; j++) begin
      @(posedge clk); #1;
      if (j < NVEC) begin in_valid = 1'b1; op = tbl[j].op; end
      else in_valid = 1'b0;
      @(negedge clk);
      check("tbl_in_ready", 32'(in_ready), 32'd1);
      if (j >= 4) begin
        check($sformatf("tbl%0d_valid", j - 4), 32'(out_valid), 32'd1);
        check($sformatf("tbl%0d_rne", j - 4),   result,         tbl[j-4].rne);
        check($sformatf("tbl%0d_away", j - 4),  ta_result,      tbl[j-4].away);
      end else begin
        check("tbl_lat_valid", 32'(out_valid), 32'd0);
      end
    end

    // Back-pressure: stall four cycles as soon as the first result shows.
    drain();
    k = 0; m = 0; stall = 0; bp_started = 1'b0;
    for (int c = 0; c < 40 && m < 5; c++) begin
      @(posedge clk); #1;
      if (out_valid && !bp_started) begin bp_started = 1'b1; stall = 4; end
      if (stall > 0) begin out_ready = 1'b0; stall--; end
      else out_ready = 1'b1;
      in_valid = (k < 5);
      op = (k < 5) ? bp_ops[k] : 32'd0;
      @(negedge clk);
      if (!out_ready) begin
        check("bp_in_ready", 32'(in_ready),  32'd0);
        check("bp_hold",     result,         32'h4120_0000);
        check("bp_valid",    32'(out_valid), 32'd1);
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_out%0d", m), result, bp_exp[m]);
        m++;
      end
      if (in_valid && in_ready) k++;
    end
    check("bp_count", 32'(m), 32'd5);

    // Bubbles travel through untouched.
    drain();
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      in_valid = (j == 0 || j == 2);
      op = (j == 0) ? 32'd5 : (j == 2) ? 32'd7 : 32'd0;
      @(negedge clk);
      check($sformatf("bub%0d_valid", j), 32'(out_valid), (j == 4 || j == 6) ? 32'd1 : 32'd0);
      if (j == 4) check("bub_5", result, 32'h40A0_0000);
      if (j == 6) check("bub_7", result, 32'h40E0_0000);
    end

    // Reset pulse between edges with the pipe full.
    drain();
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      in_valid = (j < 3);
      op = 32'd100 + 32'(j);
      @(negedge clk);
      if (j == 4) check("rstm_pre_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rstm_valid",    32'(out_valid), 32'd0);
    check("rstm_result",   result,         32'd0);
    check("rstm_in_ready", 32'(in_ready),  32'd1);
    #4 rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("rstm_no_ghost", 32'(out_valid), 32'd0);
    end
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      in_valid = (j == 0);
      op = 32'd2;
      @(negedge clk);
      check($sformatf("rstm2_valid%0d", j), 32'(out_valid), (j == 4) ? 32'd1 : 32'd0);
      if (j == 4) begin
        check("rstm2_rne",  result,    32'h4000_0000);
        check("rstm2_away", ta_result, 32'h4000_0000);
      end
    end

    // Randomized traffic with random back-pressure against the model.
    drain();
    sb_q.delete();
    pending = 1'b0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk); #1;
      if (c < 400) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!pending) begin
          in_valid = ($urandom_range(0, 2) != 0);
          op       = rand_op();
        end
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      @(negedge clk);
      check("rand_ta_valid", 32'(ta_out_valid), 32'(out_valid));
      if (in_valid && in_ready) sb_q.push_back(op);
      pending = in_valid && !in_ready;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand_extra: got result %h, expected no output", result);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("rand_rne_%h", e),  result,    model(e, 1'b0));
          check($sformatf("rand_away_%h", e), ta_result, model(e, 1'b1));
        end
      end
    end
    check("rand_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
